// File: rtl/anc_pkg.sv
// Shared types for the ANC sample source: sample width, frame entry layout,
// sequencer states and the default controller init delay.
package anc_pkg;

  localparam int SAMPLE_W        = 16;
  localparam int INIT_CYCLES_DEF = 64;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t e;
    sample_t x;
    sample_t a;
    sample_t u;
  } frame_t;

  typedef enum logic {
    WAIT_INIT = 1'b0,
    RUN       = 1'b1
  } state_t;

endpackage

// File: rtl/anc_sample_fifo.sv
// Frame FIFO with a registered head; a push into an empty FIFO is visible on head one cycle later.
// Push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
module anc_sample_fifo
  import anc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  frame_t                   push_dat,
  input  logic                     pop,
  output frame_t                   head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  frame_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_next;
  logic [LW-1:0]   level_after_pop;
  logic            pop_en;
  logic            push_en;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);

  assign rd_next         = rd_ptr + AW'(pop_en);
  assign level_after_pop = level - LW'(pop_en);

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      head_dat <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      level  <= level_after_pop + LW'(push_en);
      // The next head is still being written when the FIFO drains to zero this cycle.
      if (push_en && level_after_pop == '0) head_dat <= push_dat;
      else                                  head_dat <= mem[rd_next];
    end
  end

endmodule

// File: rtl/anc_sample_source.sv
// ADC frame source for the ANC controller: init sequencer, frame FIFO (1-cycle latency), DAC capture.
// Frames are held until controller_ready; pushes into a full FIFO drop. Macro: ANC_SRC_DROP_CNT_EN.
module anc_sample_source
  import anc_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int INIT_CYCLES = INIT_CYCLES_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        adc_strobe,
  input  logic signed [15:0]          adc_e,
  input  logic signed [15:0]          adc_x,
  input  logic signed [15:0]          adc_a,
  input  logic signed [15:0]          step_u,
  output logic                        init_done,
  output logic                        in_valid,
  input  logic                        controller_ready,
  output logic signed [15:0]          e_in,
  output logic signed [15:0]          x_in,
  output logic signed [15:0]          a_in,
  output logic signed [15:0]          u_in,
  input  logic                        out_valid,
  input  logic signed [15:0]          out_sample,
  output logic                        dac_strobe,
  output logic signed [15:0]          dac_sample,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        overflow,
  output logic [15:0]                 drop_cnt
);

  localparam int CW = $clog2(INIT_CYCLES + 1);

  state_t          state;
  logic [CW-1:0]   init_cnt;
  frame_t          head;
  frame_t          frame;
  logic            fifo_full;
  logic            fifo_empty;
  logic            accept;
  logic            pop;
  logic            push;
  logic            drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= WAIT_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        WAIT_INIT: begin
          if (init_cnt == CW'(INIT_CYCLES - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + CW'(1);
          end
        end
        default: init_done <= 1'b1;
      endcase
    end
  end

  // in_valid depends only on registered state, never on controller_ready.
  assign in_valid = (state == RUN) & ~fifo_empty;
  assign pop      = in_valid & controller_ready;
  assign accept   = (state == RUN) & adc_strobe;
  assign drop     = accept & fifo_full & ~pop;
  assign push     = accept & ~drop;

  assign frame = '{e: adc_e, x: adc_x, a: adc_a, u: step_u};

  anc_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (frame),
    .pop      (pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign e_in = head.e;
  assign x_in = head.x;
  assign a_in = head.a;
  assign u_in = head.u;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      dac_strobe <= 1'b0;
      dac_sample <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      dac_strobe <= out_valid;
      if (out_valid) dac_sample <= out_sample;
    end
  end

`ifdef ANC_SRC_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                        drop_q <= '0;
    else if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_anc_sample_source.sv
// Directed bench for anc_sample_source: init sequencing, handshake, backpressure/overflow, DAC capture, mid-run reset.
module tb_anc_sample_source;

`ifdef ANC_SRC_DROP_CNT_EN
  localparam logic [15:0] DROP_ONE = 16'd1;
`else
  localparam logic [15:0] DROP_ONE = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_strobe = 1'b0;
  logic [15:0] adc_e = '0, adc_x = '0, adc_a = '0, step_u = '0;
  logic        controller_ready = 1'b0;
  logic        out_valid = 1'b0;
  logic [15:0] out_sample = '0;
  logic        init_done, in_valid, dac_strobe, overflow;
  logic [15:0] e_in, x_in, a_in, u_in, dac_sample, drop_cnt;
  logic [2:0]  fifo_level;

  int vectors = 0;
  int miscompares = 0;

  anc_sample_source #(.DEPTH(4), .INIT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .adc_strobe(adc_strobe),
    .adc_e(adc_e), .adc_x(adc_x), .adc_a(adc_a), .step_u(step_u),
    .init_done(init_done), .in_valid(in_valid), .controller_ready(controller_ready),
    .e_in(e_in), .x_in(x_in), .a_in(a_in), .u_in(u_in),
    .out_valid(out_valid), .out_sample(out_sample),
    .dac_strobe(dac_strobe), .dac_sample(dac_sample),
    .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        strb;
    logic [63:0] frm;
    logic        rdy;
    logic        ov;
    logic [15:0] os;
    logic        exp_vld;
    logic [63:0] exp_frm;
    logic [2:0]  exp_lvl;
    logic        exp_ovf;
    logic        exp_dst;
    logic [15:0] exp_dac;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] fr(input int n);
    logic [15:0] k;
    k = 16'(n);
    return {16'h1000 | k, 16'h2000 | k, 16'h3000 | k, 16'h4000 | k};
  endfunction

  task automatic add(input logic strb, input logic [63:0] frm, input logic rdy,
                     input logic ov, input logic [15:0] os, input logic exp_vld,
                     input logic [63:0] exp_frm, input logic [2:0] exp_lvl,
                     input logic exp_ovf, input logic exp_dst, input logic [15:0] exp_dac);
    vec_t v;
    v.strb = strb; v.frm = frm; v.rdy = rdy; v.ov = ov; v.os = os;
    v.exp_vld = exp_vld; v.exp_frm = exp_frm; v.exp_lvl = exp_lvl;
    v.exp_ovf = exp_ovf; v.exp_dst = exp_dst; v.exp_dac = exp_dac;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic strb, input logic [63:0] f);
    adc_strobe = strb;
    {adc_e, adc_x, adc_a, step_u} = f;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " init_done"}, 64'(init_done), 0);
    chk({tag, " in_valid"}, 64'(in_valid), 0);
    chk({tag, " level"}, 64'(fifo_level), 0);
    chk({tag, " head"}, {e_in, x_in, a_in, u_in}, 0);
    chk({tag, " dac_strobe"}, 64'(dac_strobe), 0);
    chk({tag, " dac_sample"}, 64'(dac_sample), 0);
    chk({tag, " overflow"}, 64'(overflow), 0);
    chk({tag, " drop_cnt"}, 64'(drop_cnt), 0);
  endtask

  // Releases reset, strobes at cycle 10 (must be ignored), checks init_done timing.
  task automatic run_init(input string tag);
    rst_n = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      drive_frame(k == 10, 64'h0BAD_0BAD_0BAD_0BAD);
      step();
      if (k == 10) chk({tag, " no push in init"}, 64'(fifo_level), 0);
      if (k == 11) chk({tag, " no valid in init"}, 64'(in_valid), 0);
      if (k == 63) chk({tag, " init_done@63"}, 64'(init_done), 0);
      if (k == 64) chk({tag, " init_done@64"}, 64'(init_done), 1);
    end
    drive_frame(1'b0, '0);
    step();
    chk({tag, " level after init"}, 64'(fifo_level), 0);
    chk({tag, " overflow after init"}, 64'(overflow), 0);
  endtask

  initial begin
    // strb frm rdy ov os | vld exp_frm lvl ovf dst dac
    add(1, 64'h0100_FF00_0010_0002, 1, 0, 0, 1, 64'h0100_FF00_0010_0002, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 4; n++) add(1, fr(n), 0, 0, 0, 1, fr(1), 3'(n), 0, 0, 0);
    add(1, fr(5), 0, 0, 0, 1, fr(1), 4, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, fr(2), 3, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, fr(3), 2, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, fr(4), 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int n = 6; n <= 9; n++) add(1, fr(n), 0, 0, 0, 1, fr(6), 3'(n - 5), 1, 0, 0);
    add(1, fr(10), 1, 0, 0, 1, fr(7), 4, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, fr(8), 3, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, fr(9), 2, 1, 0, 0);
    add(0, 0, 1, 0, 0, 1, fr(10), 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 16'h8001, 0, 0, 0, 1, 1, 16'h8001);
    add(0, 0, 0, 0, 16'h1234, 0, 0, 0, 1, 0, 16'h8001);
    add(0, 0, 0, 0, 16'h5678, 0, 0, 0, 1, 0, 16'h8001);

    // Reset state
    step(); step();
    check_all_zero("reset");
    run_init("init");

    foreach (vecs[i]) begin
      string id;
      id = $sformatf("v%0d", i);
      drive_frame(vecs[i].strb, vecs[i].frm);
      controller_ready = vecs[i].rdy;
      out_valid = vecs[i].ov;
      out_sample = vecs[i].os;
      step();
      chk({id, " in_valid"}, 64'(in_valid), 64'(vecs[i].exp_vld));
      chk({id, " level"}, 64'(fifo_level), 64'(vecs[i].exp_lvl));
      chk({id, " overflow"}, 64'(overflow), 64'(vecs[i].exp_ovf));
      chk({id, " drop_cnt"}, 64'(drop_cnt), vecs[i].exp_ovf ? 64'(DROP_ONE) : 64'd0);
      chk({id, " dac_strobe"}, 64'(dac_strobe), 64'(vecs[i].exp_dst));
      chk({id, " dac_sample"}, 64'(dac_sample), 64'(vecs[i].exp_dac));
      if (vecs[i].exp_vld) begin
        chk({id, " e_in"}, 64'(e_in), 64'(vecs[i].exp_frm[63:48]));
        chk({id, " x_in"}, 64'(x_in), 64'(vecs[i].exp_frm[47:32]));
        chk({id, " a_in"}, 64'(a_in), 64'(vecs[i].exp_frm[31:16]));
        chk({id, " u_in"}, 64'(u_in), 64'(vecs[i].exp_frm[15:0]));
      end
    end

    // Mid-run reset with three frames queued and a pending (unaccepted) head.
    controller_ready = 1'b0;
    out_valid = 1'b0;
    for (int n = 11; n <= 13; n++) begin
      drive_frame(1'b1, fr(n));
      step();
    end
    drive_frame(1'b0, '0);
    chk("midrun level", 64'(fifo_level), 3);
    chk("midrun in_valid", 64'(in_valid), 1);
    controller_ready = 1'b1;
    rst_n = 1'b0;
    step();
    check_all_zero("midrun reset");
    controller_ready = 1'b0;
    run_init("reinit");

    // A fresh frame after re-init travels normally.
    drive_frame(1'b1, fr(14));
    step();
    drive_frame(1'b0, '0);
    chk("post-reinit in_valid", 64'(in_valid), 1);
    chk("post-reinit head", {e_in, x_in, a_in, u_in}, fr(14));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
